// File: rtl/bp_be_dcache_pkg.sv
// Shared types for the D$ maintenance-packet arbiter: channel select, FSM states, mod-3 helper.
package bp_be_dcache_pkg;

    typedef enum logic [1:0] {
        e_sel_data = 2'd0,
        e_sel_tag  = 2'd1,
        e_sel_stat = 2'd2
    } bp_be_dcache_pkt_sel_e;

    typedef enum logic {
        e_idle = 1'b0,
        e_wait = 1'b1
    } bp_be_dcache_arb_state_e;

    // Operands are channel indices (0..2) plus an offset (0..2), so one subtraction suffices.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bp_be_rr_pick3.sv
// Purpose: 3-way rotating-priority picker; first eligible channel at or after ptr, mod 3.
// Latency: combinational.
// Backpressure: none; pure function of eligible and ptr.
module bp_be_rr_pick3
    import bp_be_dcache_pkg::*;
(
    input  logic [2:0] eligible,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       winner_v
);

    logic [1:0] idx;

    // Scan farthest offset first so the nearest eligible channel is the last to be written.
    always_comb begin
        winner   = 2'd0;
        winner_v = 1'b0;
        idx      = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = wrap3({1'b0, ptr} + 3'(k));
            if (eligible[idx]) begin
                winner   = idx;
                winner_v = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_be_dcache_pkt_arbiter.sv
// Purpose: round-robin share of the single-ported D$ maintenance port among data/tag/stat packet streams.
// Latency: packet presented in the same cycle it is valid when idle; result visible the cycle after the response.
// Backpressure: packet held until cache_pkt_ready_i; yumi pulses only on the accepting cycle.
module bp_be_dcache_pkt_arbiter
    import bp_be_dcache_pkg::*;
#(
    parameter int data_pkt_width_p = 64,
    parameter int tag_pkt_width_p  = 48,
    parameter int stat_pkt_width_p = 16,
    parameter int block_width_p    = 512,
    parameter int ptag_width_p     = 28,
    parameter int stat_width_p     = 15,
    parameter int timeout_p        = 255,
    localparam int pkt_width_lp    = max3(data_pkt_width_p, tag_pkt_width_p, stat_pkt_width_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [data_pkt_width_p-1:0] data_pkt_i,
    input  logic                        data_pkt_v_i,
    output logic                        data_pkt_yumi_o,
    output logic [block_width_p-1:0]    data_o,

    input  logic [tag_pkt_width_p-1:0]  tag_pkt_i,
    input  logic                        tag_pkt_v_i,
    output logic                        tag_pkt_yumi_o,
    output logic [ptag_width_p-1:0]     tag_o,

    input  logic [stat_pkt_width_p-1:0] stat_pkt_i,
    input  logic                        stat_pkt_v_i,
    output logic                        stat_pkt_yumi_o,
    output logic [stat_width_p-1:0]     stat_o,

    input  logic                        crit_i,

    output logic [pkt_width_lp-1:0]     cache_pkt_o,
    output logic [1:0]                  cache_pkt_sel_o,
    output logic                        cache_pkt_v_o,
    input  logic                        cache_pkt_ready_i,

    input  logic                        cache_resp_v_i,
    input  logic [block_width_p-1:0]    cache_resp_i,

    output logic                        busy_o,
    output logic                        err_o
);

    localparam int cnt_width_lp = $clog2(timeout_p + 1);
    localparam logic [cnt_width_lp-1:0] timeout_lp = cnt_width_lp'(timeout_p);

    bp_be_dcache_arb_state_e state_r, state_n;
    bp_be_dcache_pkt_sel_e   sel_r;
    logic [1:0]              ptr_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    err_r;

    logic [2:0] eligible;
    logic [1:0] winner;
    logic       winner_v;
    logic       issue_win;
    logic       hs;
    logic       resp_in_wait;
    logic       wait_no_resp;

    // A critical fill locks out tag/stat traffic entirely.
    assign eligible = crit_i ? {2'b00, data_pkt_v_i}
                             : {stat_pkt_v_i, tag_pkt_v_i, data_pkt_v_i};

    bp_be_rr_pick3 pick (
        .eligible (eligible),
        .ptr      (ptr_r),
        .winner   (winner),
        .winner_v (winner_v)
    );

    assign resp_in_wait = (state_r == e_wait) & cache_resp_v_i;
    assign wait_no_resp = (state_r == e_wait) & ~cache_resp_v_i;

    always_comb begin
        state_n         = state_r;
        issue_win       = 1'b0;
        cache_pkt_v_o   = 1'b0;
        cache_pkt_o     = '0;
        cache_pkt_sel_o = winner;
        hs              = 1'b0;
        data_pkt_yumi_o = 1'b0;
        tag_pkt_yumi_o  = 1'b0;
        stat_pkt_yumi_o = 1'b0;

        // Reset gating keeps the D$ port quiet while reset is held, independent of clk.
        issue_win     = ~reset_i & ((state_r == e_idle) | resp_in_wait);
        cache_pkt_v_o = issue_win & winner_v;
        hs            = cache_pkt_v_o & cache_pkt_ready_i;

        case (winner)
            e_sel_data: cache_pkt_o[data_pkt_width_p-1:0] = data_pkt_i;
            e_sel_tag:  cache_pkt_o[tag_pkt_width_p-1:0]  = tag_pkt_i;
            e_sel_stat: cache_pkt_o[stat_pkt_width_p-1:0] = stat_pkt_i;
            default:    cache_pkt_o = '0;
        endcase

        data_pkt_yumi_o = hs & (winner == e_sel_data);
        tag_pkt_yumi_o  = hs & (winner == e_sel_tag);
        stat_pkt_yumi_o = hs & (winner == e_sel_stat);

        case (state_r)
            e_idle:  if (hs) state_n = e_wait;
            e_wait:  if (hs) state_n = e_wait;
                     else if (cache_resp_v_i) state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            sel_r   <= e_sel_data;
            ptr_r   <= 2'd0;
        end else begin
            state_r <= state_n;
            if (hs) begin
                sel_r <= bp_be_dcache_pkt_sel_e'(winner);
                if (!crit_i) ptr_r <= wrap3({1'b0, winner} + 3'd1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= '0;
            tag_o  <= '0;
            stat_o <= '0;
        end else if (resp_in_wait) begin
            case (sel_r)
                e_sel_data: data_o <= cache_resp_i;
                e_sel_tag:  tag_o  <= cache_resp_i[ptag_width_p-1:0];
                e_sel_stat: stat_o <= cache_resp_i[stat_width_p-1:0];
                default:    ;
            endcase
        end
    end

    // The FSM keeps waiting past the timeout; err_o only flags it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (hs) cnt_r <= '0;
            else if (wait_no_resp && cnt_r != timeout_lp) cnt_r <= cnt_r + cnt_width_lp'(1);
            if (wait_no_resp && cnt_r == timeout_lp - cnt_width_lp'(1)) err_r <= 1'b1;
        end
    end

    assign busy_o = (state_r == e_wait);
    assign err_o  = err_r;

endmodule

// File: doc/bp_be_dcache_pkt_arbiter.md
Name: bp_be_dcache_pkt_arbiter

Overview:
- Shares the D$ single-ported maintenance interface among the LCE's three fill/probe packet streams: data_mem, tag_mem and stat_mem.
- Sits between the LCE packet outputs and the D$ inside the BE calculator.
- Grants one packet at a time, round-robin, and tracks the single outstanding access.
- Routes the D$ response back to the issuing channel and holds it in a per-channel result register.

Parameters:
data_pkt_width_p, 64, width of data_mem packet
tag_pkt_width_p, 48, width of tag_mem packet
stat_pkt_width_p, 16, width of stat_mem packet
block_width_p, 512, D$ block width; width of the response bus
ptag_width_p, 28, tag result width
stat_width_p, 15, stat result width
timeout_p, 255, maximum cycles a response may be outstanding before err_o

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
data_pkt_i  in  data_pkt_width_p  data_mem packet
data_pkt_v_i  in  1  data packet valid
data_pkt_yumi_o  out  1  data packet consumed
data_o  out  block_width_p  last data response
tag_pkt_i  in  tag_pkt_width_p  tag_mem packet
tag_pkt_v_i  in  1  tag packet valid
tag_pkt_yumi_o  out  1  tag packet consumed
tag_o  out  ptag_width_p  last tag response
stat_pkt_i  in  stat_pkt_width_p  stat_mem packet
stat_pkt_v_i  in  1  stat packet valid
stat_pkt_yumi_o  out  1  stat packet consumed
stat_o  out  stat_width_p  last stat response
crit_i  in  1  critical fill in progress; only the data channel is eligible
cache_pkt_o  out  max(data,tag,stat pkt widths)  selected packet, zero-extended
cache_pkt_sel_o  out  2  selected channel: 0 data, 1 tag, 2 stat
cache_pkt_v_o  out  1  packet valid to D$
cache_pkt_ready_i  in  1  D$ accepts packet
cache_resp_v_i  in  1  D$ response valid
cache_resp_i  in  block_width_p  D$ response
busy_o  out  1  an access is outstanding
err_o  out  1  sticky response timeout

Behaviour:
- Reset (async, active-high) sets:
  - state e_idle
  - RR pointer 0
  - all result registers 0
  - timeout counter 0
  - err_o 0
  - all yumi outputs 0, cache_pkt_v_o 0, busy_o 0
- FSM has two states: e_idle and e_wait.
- Issue window = (state==e_idle) or (state==e_wait and cache_resp_v_i). This allows back-to-back issue in the cycle the response returns.
- Eligibility:
  - When crit_i=1, only the data channel is eligible.
  - Otherwise all channels are eligible; eligible = eligible and valid.
- Winner selection: the first eligible channel scanning from the RR pointer upward, mod 3.
- In the issue window with a winner, the block drives cache_pkt_v_o=1, cache_pkt_o=winner packet (upper bits zero) and cache_pkt_sel_o=winner.
  - All outputs are combinational from inputs plus state.
  - cache_pkt_v_o must not depend on cache_pkt_ready_i.
- Handshake completes when cache_pkt_v_o & cache_pkt_ready_i:
  - Winner's yumi=1 in the same cycle; other yumis stay 0.
  - Latch sel_r=winner.
  - RR pointer <= (winner+1) mod 3. The pointer is unchanged when the winner is selected under crit_i.
  - Next state e_wait; timeout counter cleared.
- Without a handshake, the state holds. If the state was e_wait and the response arrived, the next state is e_idle.
- On cache_resp_v_i in e_wait, the result register indexed by sel_r is written:
  - data_o <= cache_resp_i
  - tag_o <= cache_resp_i[ptag_width_p-1:0]
  - stat_o <= cache_resp_i[stat_width_p-1:0]
  - Results are visible the next cycle and held until the next response to the same channel.
- cache_resp_v_i in e_idle is ignored and leaves no state change.
- busy_o = (state==e_wait).
- Timeout counter:
  - Increments each e_wait cycle without a response and saturates.
  - On reaching timeout_p, err_o is set and stays set until reset.
  - The FSM keeps waiting after the timeout.
- If every valid channel is ineligible, no packet is issued and the pointer holds.
- Latency from valid to packet presented is 0 cycles when idle. Steady-state throughput is one packet per cycle when the D$ responds in the following cycle.

Decomposition:
- Add to bp_be_dcache_pkg:
  - enum bp_be_dcache_pkt_sel_e {e_sel_data, e_sel_tag, e_sel_stat}
  - FSM state enum
- Sub-module bp_be_rr_pick3: a combinational 3-way rotating-priority picker with inputs eligible[2:0] and ptr, and outputs winner and winner_v.

Test Plan:
- After reset, only tag_pkt_v_i=1 and ready=1 → cycle 0: cache_pkt_v_o=1, sel=1, tag_pkt_yumi_o=1. Response 0x…ABC next cycle → tag_o=0xABC one cycle later.
- All three valid, ready=1, response every cycle following issue → grant order data,tag,stat,data; each yumi pulses once per grant.
- crit_i=1 with all valid → only data granted for 4 consecutive accesses; pointer stays 0; crit_i=0 → next grant is data, then tag.
- ready=0 for 5 cycles with data valid → cache_pkt_v_o held 1, yumi 0, no state change; ready=1 → single yumi.
- No response for timeout_p cycles → err_o=1 at cycle timeout_p and stays set; late response still updates data_o and returns to e_idle.
- Assert reset_i mid-e_wait → outputs clear asynchronously; a subsequent stray cache_resp_v_i is ignored and all results stay 0.
